// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the program counter, drives a req/ack
// instruction-memory port with wait-state tolerance, honours StallF and
// applies decode-resolved branch/jump redirects, discarding wrong-path
// responses to requests already in flight.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        PCSrcD,
    input  logic [31:0] PcBranchD,
    input  logic        JumpD,
    input  logic [31:0] PcJumpD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrF,
    output logic [31:0] PcPlusFourF,
    output logic        ValidF,
    output logic        FetchMissF
);

    // FETCH: request outstanding for pc_f
    // HOLD : instruction captured while stalled, no request outstanding
    // DROP : wrong-path request still outstanding, its response is discarded
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc_f;
    logic [31:0] drop_addr;
    logic [31:0] instr_buf;
    logic [31:0] pc_plus_four;
    logic [31:0] target;
    logic        redirect;

    // A stalled fetch stage ignores redirects; branch wins over jump.
    assign redirect     = !StallF && (PCSrcD || JumpD);
    assign target       = PCSrcD ? PcBranchD : PcJumpD;
    assign pc_plus_four = pc_f + 32'd4;

    // PC, buffers and handshake state advance on each accepted response or redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            pc_f      <= RESET_PC;
            drop_addr <= '0;
            instr_buf <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        if (!StallF) begin
                            pc_f <= redirect ? target : pc_plus_four;
                        end else begin
                            instr_buf <= imem_rdata;
                            state     <= HOLD;
                        end
                    end else if (redirect) begin
                        // Keep presenting the old address until its ack arrives.
                        drop_addr <= pc_f;
                        pc_f      <= target;
                        state     <= DROP;
                    end
                end
                HOLD: begin
                    if (!StallF) begin
                        pc_f  <= redirect ? target : pc_plus_four;
                        state <= FETCH;
                    end
                end
                DROP: begin
                    if (redirect) begin
                        pc_f <= target;
                    end
                    if (imem_ack) begin
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    // Memory port and decode-facing outputs; reset forces an idle, invalid view.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_f;
        InstrF    = instr_buf;
        ValidF    = 1'b0;
        if (reset) begin
            InstrF = '0;
        end else begin
            case (state)
                FETCH: begin
                    imem_req  = 1'b1;
                    imem_addr = pc_f;
                    InstrF    = imem_rdata;
                    ValidF    = imem_ack;
                end
                HOLD: begin
                    ValidF = 1'b1;
                end
                DROP: begin
                    imem_req  = 1'b1;
                    imem_addr = drop_addr;
                end
                default: begin
                    imem_req = 1'b0;
                end
            endcase
        end
    end

    assign FetchMissF  = !ValidF;
    assign PcPlusFourF = reset ? (RESET_PC + 32'd4) : pc_plus_four;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: the bench plays the instruction memory,
// pushes each good-path instruction it returns onto a scoreboard queue and
// compares InstrF against the queue head whenever ValidF is expected.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF;
    logic        PCSrcD;
    logic [31:0] PcBranchD;
    logic        JumpD;
    logic [31:0] PcJumpD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] InstrF;
    logic [31:0] PcPlusFourF;
    logic        ValidF;
    logic        FetchMissF;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .StallF      (StallF),
        .PCSrcD      (PCSrcD),
        .PcBranchD   (PcBranchD),
        .JumpD       (JumpD),
        .PcJumpD     (PcJumpD),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .InstrF      (InstrF),
        .PcPlusFourF (PcPlusFourF),
        .ValidF      (ValidF),
        .FetchMissF  (FetchMissF)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance past the edge.
    task automatic cyc(input string tag, input logic st,
                       input logic br, input logic [31:0] bt,
                       input logic jp, input logic [31:0] jt,
                       input logic ack, input logic [31:0] rd,
                       input logic ereq, input logic [31:0] eaddr,
                       input logic evld, input logic [31:0] epc4);
        logic [31:0] head;
        StallF     = st;
        PCSrcD     = br;
        PcBranchD  = bt;
        JumpD      = jp;
        PcJumpD    = jt;
        imem_ack   = ack;
        imem_rdata = rd;
        if (ack && evld) exp_q.push_back(rd);
        #2;
        chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, ereq});
        if (ereq) chk({tag, ".addr"}, imem_addr, eaddr);
        chk({tag, ".valid"}, {31'd0, ValidF}, {31'd0, evld});
        chk({tag, ".miss"}, {31'd0, FetchMissF}, {31'd0, !evld});
        chk({tag, ".pc4"}, PcPlusFourF, epc4);
        if (evld) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL %s.instr: observed=%h expected=<scoreboard empty>", tag, InstrF);
            end else begin
                head = exp_q[0];
                chk({tag, ".instr"}, InstrF, head);
                if (!st) void'(exp_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_check(input string tag, input logic ack);
        reset      = 1'b1;
        imem_ack   = ack;
        imem_rdata = 32'hDEAD_BEEF;
        #2;
        chk({tag, ".req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, ".valid"}, {31'd0, ValidF}, 32'd0);
        chk({tag, ".miss"}, {31'd0, FetchMissF}, 32'd1);
        chk({tag, ".instr"}, InstrF, 32'd0);
        chk({tag, ".pc4"}, PcPlusFourF, 32'h4);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; StallF = 0; PCSrcD = 0; PcBranchD = 0; JumpD = 0; PcJumpD = 0;
        imem_ack = 0; imem_rdata = 0;
        @(posedge clk);
        #1;
        reset_check("rst0", 1'b0);
        reset_check("rst1", 1'b0);
        reset = 1'b0;

        // Zero-wait streaming
        cyc("zw0", 0, 0, 0, 0, 0, 1, 32'h1111_0000, 1, 32'h0, 1, 32'h4);
        cyc("zw1", 0, 0, 0, 0, 0, 1, 32'h1111_0004, 1, 32'h4, 1, 32'h8);
        cyc("zw2", 0, 0, 0, 0, 0, 1, 32'h1111_0008, 1, 32'h8, 1, 32'hC);

        // Restart and fetch 0x0 with two wait states
        reset_check("rst2", 1'b0);
        reset = 1'b0;
        cyc("ws0", 0, 0, 0, 0, 0, 0, 32'hXXXX_XXXX, 1, 32'h0, 0, 32'h4);
        cyc("ws1", 0, 0, 0, 0, 0, 0, 32'hXXXX_XXXX, 1, 32'h0, 0, 32'h4);
        cyc("ws2", 0, 0, 0, 0, 0, 1, 32'h2222_0000, 1, 32'h0, 1, 32'h4);

        // Stall on the ack at 0x4, hold for 3 stall cycles, then resume at 0x8
        cyc("st0", 1, 0, 0, 0, 0, 1, 32'h8C01_0004, 1, 32'h4, 1, 32'h8);
        cyc("hd0", 1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h8);
        cyc("hd1", 1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h8);
        cyc("hd2", 1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h8);
        cyc("hd3", 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h8);

        // Branch while 0x8 is pending: address held, response dropped, then 0x40
        cyc("br0", 0, 1, 32'h40, 0, 0, 0, 32'h0, 1, 32'h8, 0, 32'hC);
        cyc("br1", 0, 0, 0, 0, 0, 0, 32'h0, 1, 32'h8, 0, 32'h44);
        cyc("br2", 0, 0, 0, 0, 0, 1, 32'hBAD0_0008, 1, 32'h8, 0, 32'h44);
        cyc("br3", 0, 0, 0, 0, 0, 1, 32'h3333_0040, 1, 32'h40, 1, 32'h44);

        // Stall into HOLD at 0x44, leave HOLD with a jump to 0x100
        cyc("hj0", 1, 0, 0, 0, 0, 1, 32'h4444_0044, 1, 32'h44, 1, 32'h48);
        cyc("hj1", 1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h48);
        cyc("hj2", 0, 0, 0, 1, 32'h100, 0, 32'h0, 0, 32'h0, 1, 32'h48);
        cyc("hj3", 0, 0, 0, 0, 0, 1, 32'h5555_0100, 1, 32'h100, 1, 32'h104);

        // Redirect alongside a valid fetch, then wrap at the top of the address space
        cyc("wr0", 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'h6666_0104, 1, 32'h104, 1, 32'h108);
        cyc("wr1", 0, 0, 0, 0, 0, 1, 32'h7777_FFFC, 1, 32'hFFFF_FFFC, 1, 32'h0);
        cyc("wr2", 0, 0, 0, 0, 0, 0, 32'h0, 1, 32'h0, 0, 32'h4);

        // Branch while 0x0 is pending, then reset while in DROP
        cyc("dr0", 0, 1, 32'h200, 0, 0, 0, 32'h0, 1, 32'h0, 0, 32'h4);
        cyc("dr1", 0, 0, 0, 0, 0, 0, 32'h0, 1, 32'h0, 0, 32'h204);
        reset_check("rst3", 1'b1);
        reset_check("rst4", 1'b0);
        reset = 1'b0;
        chk("sb.empty", exp_q.size(), 32'd0);
        cyc("rr0", 0, 0, 0, 0, 0, 0, 32'h0, 1, 32'h0, 0, 32'h4);
        cyc("rr1", 0, 0, 0, 0, 0, 1, 32'h8888_0000, 1, 32'h0, 1, 32'h4);
        cyc("rr2", 0, 0, 0, 0, 0, 1, 32'h8888_0004, 1, 32'h4, 1, 32'h8);
        chk("sb.drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline. It sits directly upstream of the decode pipeline register and produces the `InstrF` and `PcPlusFourF` values that register captures. It owns the program counter and drives a req/ack instruction-memory port that tolerates wait states. It honours `StallF` from the hazard unit and applies branch and jump redirects resolved in decode, squashing any wrong-path memory response.

## Interface

Parameters:

- `RESET_PC`, default 32'h00000000: PC value loaded on reset.

Ports:

- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `StallF`  in  1  hazard unit holds fetch; redirects are ignored while high.
- `PCSrcD`  in  1  taken branch resolved in decode.
- `PcBranchD`  in  32  branch target.
- `JumpD`  in  1  jump resolved in decode.
- `PcJumpD`  in  32  jump target.
- `imem_req`  out  1  memory request valid.
- `imem_addr`  out  32  word address of the request.
- `imem_ack`  in  1  request completes this cycle; may be combinational for zero-wait memory.
- `imem_rdata`  in  32  instruction; valid only when `imem_ack`=1.
- `InstrF`  out  32  fetched instruction to the decode register.
- `PcPlusFourF`  out  32  `PcF + 4` (mod 2^32).
- `ValidF`  out  1  `InstrF` is a good-path instruction this cycle.
- `FetchMissF`  out  1  equals `!ValidF`; the hazard unit uses it to stall or clear decode.

## Operation

- Registers:
  - `PcF` (32): reset value `RESET_PC`.
  - `DropAddr` (32): reset value 0.
  - `InstrBuf` (32): reset value 0.
  - `state`: reset value FETCH.
- Redirect is taken only when `StallF`=0 and (`PCSrcD` | `JumpD`).
  - Target is `PcBranchD` if `PCSrcD`, else `PcJumpD`. `PCSrcD` has priority.
- Handshake rule: once `imem_req` is high, `imem_addr` is held stable until the cycle `imem_ack`=1. The request is never withdrawn, except by reset.
- FETCH state:
  - Outputs: `imem_req`=1, `imem_addr`=`PcF`, `InstrF`=`imem_rdata`, `ValidF`=`imem_ack`.
  - ack & !StallF: `PcF`<=redirect ? target : `PcF`+4; stay FETCH.
  - ack & StallF: `InstrBuf`<=`imem_rdata`; go HOLD.
  - !ack & redirect: `DropAddr`<=`PcF`; `PcF`<=target; go DROP.
  - !ack & no redirect: no change.
- HOLD state:
  - Outputs: `imem_req`=0, `InstrF`=`InstrBuf`, `ValidF`=1.
  - StallF: stay HOLD.
  - !StallF: `PcF`<=redirect ? target : `PcF`+4; go FETCH.
- DROP state:
  - Outputs: `imem_req`=1, `imem_addr`=`DropAddr`, `ValidF`=0, `InstrF`=`InstrBuf`.
  - Redirect: `PcF`<=target and stay DROP. `DropAddr` is unchanged.
  - ack: response is discarded; go FETCH.
- `PcPlusFourF` = `PcF`+4 in every state. `PcF`=32'hFFFFFFFC wraps to 0.
- A redirect in the same cycle as a valid fetch still presents that instruction with `ValidF`=1. The hazard unit's `ClrD` squashes it in decode.
- Reset mid-operation: the outstanding request is abandoned and all registers take their reset values. The memory is reset by the same signal.

## Timing

- While `reset`=1: `imem_req`=0, `ValidF`=0, `FetchMissF`=1, `InstrF`=0, `PcPlusFourF`=`RESET_PC`+4.
- First request (`imem_addr`=`RESET_PC`) is issued in the first cycle after reset deasserts.
- Fetch latency equals memory latency:
  - Zero-wait memory (ack in the same cycle as req) sustains 1 instruction/cycle with no bubbles.
  - Each wait cycle produces one `ValidF`=0 cycle.
- Redirect with an outstanding request costs (remaining wait cycles + 1) cycles before the target request issues.
- Leaving HOLD costs one cycle before the next request issues.

## Test plan

- Zero-wait memory, `StallF`=0, reset released → `imem_addr` 0x0, 0x4, 0x8 on consecutive cycles; `ValidF`=1 each cycle; `PcPlusFourF` 0x4, 0x8, 0xC.
- `imem_ack` delayed 2 cycles at address 0x0 → `imem_req`=1 with `imem_addr`=0x0 for 3 cycles; `ValidF`=0,0,1; `InstrF`=`imem_rdata` on cycle 3.
- `StallF`=1 when ack returns 32'h8C010004 at 0x4 → `InstrF` holds 32'h8C010004 with `ValidF`=1 and `imem_req`=0 for 3 stall cycles; after `StallF` falls, next request is 0x8.
- Request to 0x8 pending, `PCSrcD`=1, `PcBranchD`=0x40 → `imem_addr` stays 0x8 until ack; that response is dropped with `ValidF`=0; next request is 0x40.
- In HOLD, `StallF` falls with `JumpD`=1, `PcJumpD`=0x100 → buffered instruction presented that cycle; next request is 0x100.
- `PcF`=0xFFFFFFFC → `PcPlusFourF`=0x0 and next request is 0x0.
- `reset` asserted in DROP → `imem_req`=0 during reset; after release, request to `RESET_PC`; stale ack not forwarded.
